commit_trace_tx: RTL and testbench
==================================

COMMIT_TRACE_TX -- requirements
Module: commit_trace_tx

Interface
REQ-001 The block SHALL have parameter PC_W, default 3, meaning committed-PC width (8-entry instruction memory).
REQ-002 The block SHALL have parameter RD_W, default 2, meaning destination-register index width (4-entry register file).
REQ-003 The block SHALL have parameter DATA_W, default 4, meaning writeback data width.
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning trace FIFO entries (power of two, >=2).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port c_valid, input, 1 bit: a commit occurs this cycle.
REQ-008 The block SHALL have ports c_pc (PC_W), c_wen (1), c_rd (RD_W) and c_data (DATA_W), all inputs: committed PC, register-write enable, destination index and writeback value, sampled when c_valid=1.
REQ-009 The block SHALL have port t_valid, output, 1 bit: a trace record is presented.
REQ-010 The block SHALL have port t_ready, input, 1 bit: the downstream checker accepts the record.
REQ-011 The block SHALL have ports t_pc, t_wen, t_rd and t_data, outputs, with the same widths as the c_* ports: the head record fields.
REQ-012 The block SHALL have port t_seq, output, 8 bits: the commit sequence number of the head record.
REQ-013 The block SHALL have port ovf, output, 1 bit: sticky flag, set when a commit record was dropped.
REQ-014 The block SHALL have port drop_cnt, output, 8 bits: saturating count of dropped records.
REQ-015 The block SHALL have port clr_ovf, input, 1 bit: synchronous clear of ovf and drop_cnt.
REQ-016 The block SHALL have port level, output, clog2(DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-017 A pop SHALL occur in any cycle where t_valid=1 and t_ready=1.
REQ-018 A push SHALL occur when c_valid=1 and either level<DEPTH or a pop occurs in the same cycle.
REQ-019 When a push occurs, the FIFO SHALL store {c_pc, c_wen, c_rd, c_data, seq} at the tail.
REQ-020 t_valid SHALL equal (level!=0).
REQ-021 The t_* outputs SHALL reflect the head entry (first-word fall-through), stable while t_valid=1 and t_ready=0.
REQ-022 A commit arriving at cycle N into an empty FIFO SHALL first appear on t_valid at cycle N+1; there SHALL be no same-cycle bypass.
REQ-023 The internal 8-bit seq counter SHALL increment on every c_valid=1 cycle, whether the record is pushed or dropped, and SHALL wrap 255->0.
REQ-024 Consequently, a gap in t_seq SHALL indicate lost commits to the checker.
REQ-025 When c_valid=1, level==DEPTH and no pop occurs, the record SHALL be dropped, ovf SHALL be set, and drop_cnt SHALL increment, saturating at 255.
REQ-026 clr_ovf=1 SHALL clear ovf and drop_cnt at the next edge.
REQ-027 If clr_ovf=1 and a drop occur in the same cycle, the result SHALL be ovf=1 and drop_cnt=1 (set wins).
REQ-028 On a simultaneous push and pop, level SHALL be unchanged, and this SHALL also hold when full.
REQ-029 Push without pop SHALL increment level; pop without push SHALL decrement level.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 The t_* field values SHALL be don't-care when t_valid=0, and the checker SHALL ignore them.

Reset
REQ-032 While rst=0 (asynchronously), the block SHALL force level=0, t_valid=0, seq=0, ovf=0, drop_cnt=0, and read/write pointers=0.
REQ-033 Reset asserted mid-stream SHALL discard all buffered records, with no partial pop or push completing.
REQ-034 FIFO storage contents SHALL NOT require reset.
REQ-035 After rst returns to 1, the first commit SHALL carry t_seq=0.

Verification
REQ-036 Bench scenario, single commit: t_ready=1, c_valid pulse with pc=5, wen=1, rd=2, data=0xA -> next cycle t_valid=1, t_pc=5, t_rd=2, t_data=0xA, t_seq=0; the following cycle t_valid=0.
REQ-037 Bench scenario, backpressure fill: t_ready=0, 4 commits -> level=4, head t_seq=0; a 5th commit -> ovf=1, drop_cnt=1; then t_ready=1 -> t_seq sequence 0,1,2,3 is drained.
REQ-038 Bench scenario, gap detection: after the REQ-037 drop, a next commit -> emitted with t_seq=5 (4 skipped).
REQ-039 Bench scenario, full with simultaneous pop: level=4, t_ready=1, c_valid=1 -> no drop, level stays 4, ovf unchanged.
REQ-040 Bench scenario, seq wrap: 257 commits with t_ready=1 -> the 256th record has t_seq=255 and the 257th has t_seq=0.
REQ-041 Bench scenario, reset mid-operation: level=3, rst=0 for one cycle -> t_valid=0 immediately and level=0; the next commit has t_seq=0; clr_ovf together with a drop -> ovf=1, drop_cnt=1.

Source files
------------

// File: rtl/commit_trace_tx.sv
// Commit trace transmitter: buffers retired-instruction records in a FIFO for a downstream checker.
// Latency: a record pushed at cycle N is first presented at cycle N+1 (first-word fall-through, no bypass).
// Backpressure: t_ready=0 holds the head stable; commits arriving while full without a pop are dropped and counted.
module commit_trace_tx #(
  parameter int PC_W   = 3,
  parameter int RD_W   = 2,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     c_valid,
  input  logic [PC_W-1:0]          c_pc,
  input  logic                     c_wen,
  input  logic [RD_W-1:0]          c_rd,
  input  logic [DATA_W-1:0]        c_data,
  output logic                     t_valid,
  input  logic                     t_ready,
  output logic [PC_W-1:0]          t_pc,
  output logic                     t_wen,
  output logic [RD_W-1:0]          t_rd,
  output logic [DATA_W-1:0]        t_data,
  output logic [7:0]               t_seq,
  output logic                     ovf,
  output logic [7:0]               drop_cnt,
  input  logic                     clr_ovf,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  localparam int REC_W = PC_W + 1 + RD_W + DATA_W + 8;

  // Record storage carries no reset; pointers and level define which entries are live.
  logic [REC_W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    seq_q, seq_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [REC_W-1:0] head;

  assign full = (level_q == LW'(DEPTH));
  assign pop  = t_valid && t_ready;
  // A full FIFO still accepts a commit when the head leaves in the same cycle.
  assign push = c_valid && (!full || pop);
  assign drop = c_valid && !push;

  assign head = mem_q[rd_ptr_q];
  assign {t_pc, t_wen, t_rd, t_data, t_seq} = head;
  assign t_valid  = (level_q != '0);
  assign level    = level_q;
  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;

  // Next-state for pointers, occupancy, sequence number and drop accounting.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    seq_d      = seq_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);

    // Every commit consumes a sequence number so the checker can see gaps from drops.
    if (c_valid) seq_d = seq_q + 8'd1;

    // A drop in the same cycle as a clear wins: the clear leaves exactly this one drop recorded.
    if (drop) begin
      ovf_d = 1'b1;
      if (clr_ovf)                 drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (clr_ovf) begin
      ovf_d      = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      seq_q      <= 8'd0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      seq_q      <= seq_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Write the incoming commit record at the tail.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {c_pc, c_wen, c_rd, c_data, seq_q};
  end

endmodule

// File: tb/tb_commit_trace_tx.sv
module tb_commit_trace_tx;

  logic       clk;
  logic       rst;
  logic       c_valid;
  logic [2:0] c_pc;
  logic       c_wen;
  logic [1:0] c_rd;
  logic [3:0] c_data;
  logic       t_valid;
  logic       t_ready;
  logic [2:0] t_pc;
  logic       t_wen;
  logic [1:0] t_rd;
  logic [3:0] t_data;
  logic [7:0] t_seq;
  logic       ovf;
  logic [7:0] drop_cnt;
  logic       clr_ovf;
  logic [2:0] level;

  int checks = 0;
  int errors = 0;

  commit_trace_tx #(.PC_W(3), .RD_W(2), .DATA_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .c_valid(c_valid), .c_pc(c_pc), .c_wen(c_wen), .c_rd(c_rd), .c_data(c_data),
    .t_valid(t_valid), .t_ready(t_ready),
    .t_pc(t_pc), .t_wen(t_wen), .t_rd(t_rd), .t_data(t_data), .t_seq(t_seq),
    .ovf(ovf), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_commit(input logic [2:0] pc, input logic wen,
                              input logic [1:0] rd, input logic [3:0] data);
    c_valid = 1'b1;
    c_pc    = pc;
    c_wen   = wen;
    c_rd    = rd;
    c_data  = data;
  endtask

  task automatic idle();
    c_valid = 1'b0;
  endtask

  task automatic apply_reset();
    c_valid = 1'b0;
    clr_ovf = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; c_valid = 1'b0; c_pc = '0; c_wen = 1'b0; c_rd = '0; c_data = '0;
    t_ready = 1'b0; clr_ovf = 1'b0;
    step();
    checks++; if (t_valid !== 1'b0) begin errors++; $display("FAIL reset_t_valid got %0b exp 0", t_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", ovf); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
    rst = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    t_ready = 1'b1;
    drive_commit(3'd5, 1'b1, 2'd2, 4'hA);
    #1;
    checks++; if (t_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %0b exp 0", t_valid); end
    step();
    idle();
    checks++; if (t_valid !== 1'b1) begin errors++; $display("FAIL single_t_valid got %0b exp 1", t_valid); end
    checks++; if ({t_pc, t_wen, t_rd, t_data} !== {3'd5, 1'b1, 2'd2, 4'hA})
      begin errors++; $display("FAIL single_fields got pc=%0d wen=%0b rd=%0d data=%h exp pc=5 wen=1 rd=2 data=a", t_pc, t_wen, t_rd, t_data); end
    checks++; if (t_seq !== 8'd0) begin errors++; $display("FAIL single_seq got %0d exp 0", t_seq); end
    step();
    checks++; if (t_valid !== 1'b0) begin errors++; $display("FAIL single_empty_after got %0b exp 0", t_valid); end
  endtask

  task automatic test_fill_and_gap();
    apply_reset();
    t_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_commit(3'(i), 1'b0, 2'(i), 4'(i + 8));
      step();
    end
    idle();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level got %0d exp 4", level); end
    checks++; if (t_seq !== 8'd0 || t_pc !== 3'd0) begin errors++; $display("FAIL fill_head got seq=%0d pc=%0d exp seq=0 pc=0", t_seq, t_pc); end
    drive_commit(3'd7, 1'b1, 2'd3, 4'hF);
    step();
    idle();
    checks++; if (ovf !== 1'b1 || drop_cnt !== 8'd1) begin errors++; $display("FAIL fill_drop got ovf=%0b cnt=%0d exp ovf=1 cnt=1", ovf, drop_cnt); end
    checks++; if (level !== 3'd4 || t_seq !== 8'd0) begin errors++; $display("FAIL fill_drop_keep got level=%0d seq=%0d exp 4 0", level, t_seq); end
    step();
    checks++; if (t_seq !== 8'd0 || t_data !== 4'h8) begin errors++; $display("FAIL fill_stall_stable got seq=%0d data=%h exp 0 8", t_seq, t_data); end
    t_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (t_valid !== 1'b1 || t_seq !== 8'(i) || t_data !== 4'(i + 8))
        begin errors++; $display("FAIL drain_%0d got v=%0b seq=%0d data=%h exp v=1 seq=%0d data=%h", i, t_valid, t_seq, t_data, i, 4'(i + 8)); end
      step();
    end
    checks++; if (level !== 3'd0 || t_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got level=%0d v=%0b exp 0 0", level, t_valid); end
    drive_commit(3'd6, 1'b1, 2'd1, 4'h3);
    step();
    idle();
    checks++; if (t_valid !== 1'b1 || t_seq !== 8'd5 || t_pc !== 3'd6)
      begin errors++; $display("FAIL gap_seq got v=%0b seq=%0d pc=%0d exp v=1 seq=5 pc=6", t_valid, t_seq, t_pc); end
    step();
  endtask

  task automatic test_full_pop();
    apply_reset();
    t_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_commit(3'(i), 1'b1, 2'd0, 4'(i));
      step();
    end
    t_ready = 1'b1;
    drive_commit(3'd4, 1'b1, 2'd0, 4'd4);
    step();
    idle();
    t_ready = 1'b0;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_pop_level got %0d exp 4", level); end
    checks++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL full_pop_nodrop got ovf=%0b cnt=%0d exp 0 0", ovf, drop_cnt); end
    checks++; if (t_seq !== 8'd1) begin errors++; $display("FAIL full_pop_head got %0d exp 1", t_seq); end
    t_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      #1;
      checks++; if (t_valid !== 1'b1 || t_seq !== 8'(i) || t_data !== 4'(i))
        begin errors++; $display("FAIL full_pop_drain_%0d got v=%0b seq=%0d data=%h exp seq=%0d", i, t_valid, t_seq, t_data, i); end
      step();
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL full_pop_empty got %0d exp 0", level); end
  endtask

  task automatic test_seq_wrap();
    int bad;
    bad = 0;
    apply_reset();
    t_ready = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      drive_commit(3'(k), 1'b0, 2'(k), 4'(k));
      step();
      if (t_seq !== 8'((k - 1) % 256) || t_data !== 4'(k)) bad++;
      if (k == 256) begin
        checks++; if (t_seq !== 8'd255) begin errors++; $display("FAIL wrap_256 got %0d exp 255", t_seq); end
      end
      if (k == 257) begin
        checks++; if (t_seq !== 8'd0) begin errors++; $display("FAIL wrap_257 got %0d exp 0", t_seq); end
      end
    end
    idle();
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_stream got %0d bad records exp 0", bad); end
    checks++; if (level !== 3'd1 || ovf !== 1'b0) begin errors++; $display("FAIL wrap_level got level=%0d ovf=%0b exp 1 0", level, ovf); end
    step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    t_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_commit(3'(i), 1'b1, 2'd1, 4'(i));
      step();
    end
    idle();
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_level_pre got %0d exp 3", level); end
    rst = 1'b0;
    #1;
    checks++; if (t_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL mid_async got v=%0b level=%0d exp 0 0", t_valid, level); end
    step();
    rst = 1'b1;
    drive_commit(3'd2, 1'b0, 2'd3, 4'h9);
    step();
    idle();
    checks++; if (t_valid !== 1'b1 || t_seq !== 8'd0 || t_data !== 4'h9 || level !== 3'd1)
      begin errors++; $display("FAIL mid_first_seq got v=%0b seq=%0d data=%h level=%0d exp 1 0 9 1", t_valid, t_seq, t_data, level); end
    for (int i = 0; i < 3; i++) begin
      drive_commit(3'(i), 1'b0, 2'd0, 4'(i));
      step();
    end
    drive_commit(3'd7, 1'b0, 2'd0, 4'd7);
    step();
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL mid_first_drop got %0d exp 1", drop_cnt); end
    step();
    checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL mid_second_drop got %0d exp 2", drop_cnt); end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    idle();
    checks++; if (ovf !== 1'b1 || drop_cnt !== 8'd1) begin errors++; $display("FAIL clr_with_drop got ovf=%0b cnt=%0d exp 1 1", ovf, drop_cnt); end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    checks++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL clr_only got ovf=%0b cnt=%0d exp 0 0", ovf, drop_cnt); end
  endtask

  task automatic test_drop_saturate();
    apply_reset();
    t_ready = 1'b0;
    for (int i = 0; i < 4 + 300; i++) begin
      drive_commit(3'd1, 1'b0, 2'd0, 4'd1);
      step();
    end
    idle();
    checks++; if (drop_cnt !== 8'd255 || ovf !== 1'b1) begin errors++; $display("FAIL saturate got cnt=%0d ovf=%0b exp 255 1", drop_cnt, ovf); end
    checks++; if (t_seq !== 8'd0 || level !== 3'd4) begin errors++; $display("FAIL saturate_head got seq=%0d level=%0d exp 0 4", t_seq, level); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_and_gap();
    test_full_pop();
    test_seq_wrap();
    test_reset_mid();
    test_drop_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
